// File: rtl/dreg_arbiter.sv
// Two-requester round-robin write arbiter in front of a small register bank.
// Each grant lasts one cycle in WRITE; the latched write lands at the edge that ends it.
module dreg_arbiter #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             busy,
    output logic             conflict
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             next_gnt0;
    logic             next_gnt1;
    logic             next_conflict;
    logic             pick1;
    logic             lp;
    logic [AW-1:0]    lat_addr;
    logic [WIDTH-1:0] lat_data;
    logic [WIDTH-1:0] bank [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= next_state;
            gnt0     <= next_gnt0;
            gnt1     <= next_gnt1;
            conflict <= next_conflict;
        end
    end

    // On a tie the requester that was not served last (lp) wins.
    always_comb begin
        next_state    = state;
        next_gnt0     = 1'b0;
        next_gnt1     = 1'b0;
        next_conflict = 1'b0;
        pick1         = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    pick1         = req1 && (!req0 || !lp);
                    next_state    = WRITE;
                    next_gnt0     = !pick1;
                    next_gnt1     = pick1;
                    next_conflict = req0 && req1;
                end
            end
            WRITE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Latch the winner's target on entry to WRITE so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr <= '0;
            lat_data <= '0;
            lp       <= 1'b1;
        end else begin
            if (state == IDLE && next_state == WRITE) begin
                lat_addr <= pick1 ? addr1 : addr0;
                lat_data <= pick1 ? data1 : data0;
            end
            if (state == WRITE) begin
                lp <= gnt1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (state == WRITE) begin
            bank[lat_addr] <= lat_data;
        end
    end

    assign busy = (state == WRITE);
    assign q    = bank[rd_addr];
    assign qn   = ~q;

endmodule

// File: tb/tb_dreg_arbiter.sv
// Directed bench for dreg_arbiter: reset, single writes, ties, round-robin,
// input changes during WRITE, reset abort and full-bank readback.
module tb_dreg_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic [1:0] addr0;
    logic [7:0] data0;
    logic       req1;
    logic [1:0] addr1;
    logic [7:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic [1:0] rd_addr;
    logic [7:0] q;
    logic [7:0] qn;
    logic       busy;
    logic       conflict;

    int checks = 0;
    int errors = 0;

    dreg_arbiter #(.WIDTH(8), .AW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .addr0    (addr0),
        .data0    (data0),
        .req1     (req1),
        .addr1    (addr1),
        .data1    (data1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rd_addr  (rd_addr),
        .q        (q),
        .qn       (qn),
        .busy     (busy),
        .conflict (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic r0, input logic [1:0] a0, input logic [7:0] d0,
                                  input logic r1, input logic [1:0] a1, input logic [7:0] d1);
        req0  = r0;
        addr0 = a0;
        data0 = d0;
        req1  = r1;
        addr1 = a1;
        data1 = d1;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] vals [4];
        vals[0] = 8'h5E;
        vals[1] = 8'hA1;
        vals[2] = 8'hC3;
        vals[3] = 8'hFF;

        rst_n   = 1'b0;
        rd_addr = 2'd0;
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        step();
        step();
        check_output("rst_gnt0", {31'd0, gnt0}, 32'd0);
        check_output("rst_gnt1", {31'd0, gnt1}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_conflict", {31'd0, conflict}, 32'd0);
        check_output("rst_q", {24'd0, q}, 32'h00);
        check_output("rst_qn", {24'd0, qn}, 32'hFF);
        rst_n = 1'b1;

        // Single request from requester 0
        rd_addr = 2'd2;
        apply_stimulus(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 8'h00);
        step();
        check_output("single_gnt0", {31'd0, gnt0}, 32'd1);
        check_output("single_gnt1", {31'd0, gnt1}, 32'd0);
        check_output("single_busy", {31'd0, busy}, 32'd1);
        check_output("single_conflict", {31'd0, conflict}, 32'd0);
        check_output("single_q_before", {24'd0, q}, 32'h00);
        req0 = 1'b0;
        step();
        check_output("single_gnt0_end", {31'd0, gnt0}, 32'd0);
        check_output("single_busy_end", {31'd0, busy}, 32'd0);
        check_output("single_q", {24'd0, q}, 32'hA5);
        check_output("single_qn", {24'd0, qn}, 32'h5A);
        step();
        check_output("single_idle_gnt0", {31'd0, gnt0}, 32'd0);

        // Tie after reset: requester 0 first, then requester 1
        pulse_reset();
        rd_addr = 2'd0;
        apply_stimulus(1'b1, 2'd0, 8'h11, 1'b1, 2'd0, 8'h22);
        step();
        check_output("tie_gnt0", {31'd0, gnt0}, 32'd1);
        check_output("tie_gnt1", {31'd0, gnt1}, 32'd0);
        check_output("tie_conflict", {31'd0, conflict}, 32'd1);
        req0 = 1'b0;
        step();
        check_output("tie_idle_conflict", {31'd0, conflict}, 32'd0);
        check_output("tie_q0", {24'd0, q}, 32'h11);
        step();
        check_output("tie_second_gnt1", {31'd0, gnt1}, 32'd1);
        check_output("tie_second_gnt0", {31'd0, gnt0}, 32'd0);
        check_output("tie_second_conflict", {31'd0, conflict}, 32'd0);
        req1 = 1'b0;
        step();
        check_output("tie_final_q", {24'd0, q}, 32'h22);
        check_output("tie_final_busy", {31'd0, busy}, 32'd0);

        // Both held: grants alternate starting at 0 since requester 1 was served last
        apply_stimulus(1'b1, 2'd1, 8'h01, 1'b1, 2'd2, 8'h02);
        for (int g = 0; g < 8; g++) begin
            step();
            check_output($sformatf("rr_gnt0_%0d", g), {31'd0, gnt0}, (g % 2 == 0) ? 32'd1 : 32'd0);
            check_output($sformatf("rr_gnt1_%0d", g), {31'd0, gnt1}, (g % 2 == 0) ? 32'd0 : 32'd1);
            check_output($sformatf("rr_conflict_%0d", g), {31'd0, conflict}, 32'd1);
            step();
            check_output($sformatf("rr_idle_%0d", g), {30'd0, gnt0, gnt1}, 32'd0);
            check_output($sformatf("rr_idle_busy_%0d", g), {31'd0, busy}, 32'd0);
        end
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        step();
        check_output("rr_done_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        rd_addr = 2'd1;
        #1;
        check_output("rr_bank1", {24'd0, q}, 32'h01);
        rd_addr = 2'd2;
        #1;
        check_output("rr_bank2", {24'd0, q}, 32'h02);

        // Inputs changed during the grant cycle are ignored
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 8'h3C);
        step();
        check_output("latch_gnt1", {31'd0, gnt1}, 32'd1);
        apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'hFF);
        step();
        rd_addr = 2'd3;
        #1;
        check_output("latch_bank3", {24'd0, q}, 32'h3C);
        rd_addr = 2'd0;
        #1;
        check_output("latch_bank0", {24'd0, q}, 32'h22);

        // Reset in the middle of WRITE aborts the write
        pulse_reset();
        rd_addr = 2'd3;
        apply_stimulus(1'b1, 2'd3, 8'h77, 1'b0, 2'd0, 8'h00);
        step();
        check_output("abort_busy_pre", {31'd0, busy}, 32'd1);
        req0  = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("abort_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();
        check_output("abort_bank3", {24'd0, q}, 32'h00);
        check_output("abort_idle", {31'd0, busy}, 32'd0);

        // Fill every address and confirm no neighbour is disturbed
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 2'(i), vals[i], 1'b0, 2'd0, 8'h00);
            step();
            req0 = 1'b0;
            step();
            for (int j = 0; j < 4; j++) begin
                rd_addr = 2'(j);
                #1;
                check_output($sformatf("fill_w%0d_r%0d", i, j), {24'd0, q},
                             (j <= i) ? {24'd0, vals[j]} : 32'h00);
            end
        end
        rd_addr = 2'd3;
        #1;
        check_output("fill_qn3", {24'd0, qn}, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dreg_arbiter.md
DREG_ARBITER -- requirements
Module: dreg_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of each bank register.
REQ-002 The block SHALL have parameter AW, default 2, giving the bank address width, so the bank holds 2**AW registers.
REQ-003 clk  input  1  Single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 req0  input  1  Write request from requester 0, held high until granted.
REQ-006 addr0  input  AW  Target register for requester 0.
REQ-007 data0  input  WIDTH  Write data for requester 0.
REQ-008 req1, addr1, data1  input  1/AW/WIDTH  The same three signals for requester 1.
REQ-009 gnt0  output  1  Registered one-cycle grant to requester 0; the write occurs at the edge that ends this cycle.
REQ-010 gnt1  output  1  Registered one-cycle grant to requester 1.
REQ-011 rd_addr  input  AW  Read address.
REQ-012 q  output  WIDTH  Combinational read, bank[rd_addr].
REQ-013 qn  output  WIDTH  Bitwise complement of q.
REQ-014 busy  output  1  High while the FSM is in WRITE.
REQ-015 conflict  output  1  Registered one-cycle pulse, high in the cycle after IDLE saw req0 and req1 both high.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and WRITE.
REQ-017 IDLE with neither request high: the FSM SHALL stay in IDLE, with gnt0 = gnt1 = 0.
REQ-018 IDLE with exactly one request high: at the next edge the FSM SHALL go to WRITE and assert that requester's grant only.
REQ-019 IDLE with both requests high: the grant SHALL go to the requester that is not the last served (pointer lp), and conflict SHALL be set for one cycle.
REQ-020 On entry to WRITE, the block SHALL latch the granted requester's addr and data into internal registers; changes on the requester inputs during WRITE SHALL have no effect.
REQ-021 At the edge that ends WRITE, the block SHALL write the latched data to the latched address, set lp to the served requester, clear both grants, and return to IDLE.
REQ-022 At most one grant SHALL be high in any cycle, and a grant SHALL last exactly one cycle.
REQ-023 Request-to-write latency SHALL be 2 edges: the request is sampled at edge N, the grant is high in cycle N..N+1, and the bank is updated at edge N+1.
REQ-024 A requester SHALL drop req at the edge that ends its grant cycle; if req is still high in the following IDLE cycle, it SHALL be treated as a new request.
REQ-025 Throughput SHALL be one write per 2 cycles; the FSM SHALL spend at least one IDLE cycle between consecutive grants.
REQ-026 Round-robin: if both requesters hold req continuously, grants SHALL alternate 0,1,0,1…, and no requester SHALL wait more than one other grant.
REQ-027 q SHALL reflect a new write in the cycle after the write edge, and qn SHALL always equal ~q.
REQ-028 Only the addressed register SHALL change on a write; a write to any address, including 2**AW-1, SHALL leave all other registers unchanged.

Reset
REQ-029 When rst_n = 0, the block SHALL immediately force: FSM = IDLE, gnt0 = gnt1 = 0, busy = 0, conflict = 0, all bank registers = 0, q = 0, qn = all ones, and lp = requester 1, so that requester 0 wins the first tie.
REQ-030 A reset asserted during WRITE SHALL abort the write, leaving no bank update.
REQ-031 After rst_n rises, the first request SHALL be sampled at the first rising edge.

Verification
REQ-032 Reset, then req0 = 1, addr0 = 2, data0 = 8'hA5 -> gnt0 high for one cycle, busy = 1; then rd_addr = 2 gives q = 8'hA5 and qn = 8'h5A.
REQ-033 After reset, req0 and req1 raised in the same cycle (addr0 = 0, data0 = 8'h11; addr1 = 0, data1 = 8'h22) -> gnt0 first with conflict = 1, then gnt1; final bank[0] = 8'h22.
REQ-034 Both requests held for 8 grants -> grant sequence is 0,1,0,1,0,1,0,1, never both grants high, and there is exactly one IDLE cycle between grants.
REQ-035 data1 changed during the gnt1 cycle (latched value 8'h3C, new value 8'hFF) -> the bank stores 8'h3C.
REQ-036 rst_n pulsed low mid-WRITE for addr 3, data 8'h77 -> bank[3] = 0, gnt = 0, and the FSM is in IDLE.
REQ-037 Writes to addr 0..3 with distinct values -> each readback matches its write, and no other address is disturbed.
